// File: rtl/dz_pkg.sv
// -----------------------------------------------------------------------------
// dz_pkg
// Shared definitions for the bi-colour dot-matrix scan controller:
//   - colour/blink mode encodings (2-bit mode input)
//   - scan FSM state type (IDLE / SCAN / BLANK)
//   - the 11-stage incubator glyph set (8x8, bit c of a row = column c lit)
//   - dz_glyph_row(): safe glyph lookup, zeros for undefined glyph/row
// -----------------------------------------------------------------------------
package dz_pkg;

    localparam logic [1:0] MODE_GREEN = 2'b00;
    localparam logic [1:0] MODE_RED   = 2'b01;
    localparam logic [1:0] MODE_AMBER = 2'b10;
    localparam logic [1:0] MODE_BLINK = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } dz_state_e;

    localparam int DZ_NUM_GLYPHS = 11;
    localparam int DZ_GLYPH_ROWS = 8;
    localparam int DZ_GLYPH_COLS = 8;

    // Stages 0-5: egg growing, 6-7: shell cracking, 8-10: chick hatching.
    localparam logic [7:0] DZ_GLYPHS [DZ_NUM_GLYPHS][DZ_GLYPH_ROWS] = '{
        '{8'h00, 8'h00, 8'h18, 8'h3C, 8'h3C, 8'h18, 8'h00, 8'h00},  // 0 seed
        '{8'h00, 8'h18, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h18, 8'h00},  // 1
        '{8'h00, 8'h3C, 8'h7E, 8'h7E, 8'h7E, 8'h7E, 8'h3C, 8'h00},  // 2
        '{8'h3C, 8'h7E, 8'h7E, 8'hFF, 8'hFF, 8'h7E, 8'h7E, 8'h3C},  // 3
        '{8'h7E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7E},  // 4
        '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF},  // 5 full egg
        '{8'hFF, 8'hFF, 8'hF7, 8'hEB, 8'hDD, 8'hFF, 8'hFF, 8'hFF},  // 6 hairline crack
        '{8'hFF, 8'hDB, 8'hA5, 8'h5A, 8'hFF, 8'hFF, 8'hFF, 8'hFF},  // 7 open crack
        '{8'h3C, 8'h42, 8'hA5, 8'h81, 8'h99, 8'h42, 8'h3C, 8'h00},  // 8 chick head
        '{8'h18, 8'h24, 8'h5A, 8'h42, 8'h7E, 8'h24, 8'h18, 8'h24},  // 9 chick standing
        '{8'h66, 8'h99, 8'h81, 8'hA5, 8'h81, 8'h42, 8'h3C, 8'h18}   // 10 chick wings
    };

    // Returns the column bits of glyph g, row r; all zeros outside the set.
    function automatic logic [7:0] dz_glyph_row(input int unsigned g, input int unsigned r);
        logic [7:0] res;
        logic [3:0] g4;
        logic [2:0] r3;
        res = '0;
        g4  = g[3:0];
        r3  = r[2:0];
        if (g < DZ_NUM_GLYPHS && r < DZ_GLYPH_ROWS) begin
            res = DZ_GLYPHS[g4][r3];
        end
        return res;
    endfunction

endpackage

// File: rtl/dz_pattern_rom.sv
// -----------------------------------------------------------------------------
// dz_pattern_rom
// Combinational glyph lookup: one COLS-bit row of the glyph selected by num_q.
// Columns beyond the 8-wide glyph art read as 0; undefined glyph numbers and
// rows beyond the glyph height give an all-zero row.
// Ports:
//   num_q   in  NUM_W  glyph index
//   row_idx in  ROW_W  matrix row
//   pat     out COLS   column pattern, bit c = column c lit
// -----------------------------------------------------------------------------
module dz_pattern_rom
    import dz_pkg::*;
#(
    parameter int NUM_W = 4,
    parameter int ROW_W = 3,
    parameter int COLS  = 8
) (
    input  logic [NUM_W-1:0] num_q,
    input  logic [ROW_W-1:0] row_idx,
    output logic [COLS-1:0]  pat
);

    logic [7:0] glyph_row;

    always_comb begin
        glyph_row = dz_glyph_row(32'(num_q), 32'(row_idx));
    end

    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_col
            if (gi < DZ_GLYPH_COLS) begin : g_art
                assign pat[gi] = glyph_row[gi];
            end else begin : g_pad
                assign pat[gi] = 1'b0;
            end
        end
    endgenerate

endmodule

// File: rtl/dz_scan_ctrl.sv
// -----------------------------------------------------------------------------
// dz_scan_ctrl
// Row-scanning driver for a ROWS x COLS bi-colour (red/green) LED matrix.
// Each row is driven for ROW_CYC cycles, followed by BLANK_CYC cycles with all
// rows off (anti-ghosting). Glyph number, mode (and brightness) are latched
// only when the scan wraps to row 0, so a frame is never torn.
//
// Optional feature macro: DZ_BRIGHTNESS_EN
//   Adds input bright[2:0]; each row slot becomes 8 sub-slots of ROW_CYC cycles
//   and the columns are lit only for the first bright+1 of them.
//
// Ports:
//   clk         in   scan clock
//   rst_n       in   asynchronous active-low reset
//   en          in   display enable (low: blank, return to row 0)
//   num         in   NUM_W glyph/stage number
//   mode        in   2 bits: 00 green, 01 red, 10 amber, 11 green blinking
//   bright      in   3 bits (DZ_BRIGHTNESS_EN only)
//   row         out  ROWS active-low one-hot row select
//   colg        out  COLS green columns, active high
//   colr        out  COLS red columns, active high
//   frame_start out  high during the first cycle of every row-0 scan slot
// -----------------------------------------------------------------------------
module dz_scan_ctrl
    import dz_pkg::*;
#(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int NUM_W     = 4,
    parameter int ROW_CYC   = 1,
    parameter int BLANK_CYC = 1,
    parameter int BLINK_FR  = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [NUM_W-1:0] num,
    input  logic [1:0]       mode,
`ifdef DZ_BRIGHTNESS_EN
    input  logic [2:0]       bright,
`endif
    output logic [ROWS-1:0]  row,
    output logic [COLS-1:0]  colg,
    output logic [COLS-1:0]  colr,
    output logic             frame_start
);

`ifdef DZ_BRIGHTNESS_EN
    localparam int SLOT_LEN = ROW_CYC * 8;
`else
    localparam int SLOT_LEN = ROW_CYC;
`endif
    localparam int ROW_W   = $clog2(ROWS);
    localparam int SLOT_W  = (SLOT_LEN > 1)  ? $clog2(SLOT_LEN)  : 1;
    localparam int BLANK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam int FR_W    = (BLINK_FR > 1)  ? $clog2(BLINK_FR)  : 1;

    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT_LEN - 1);
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [FR_W-1:0]    FR_LAST    = FR_W'(BLINK_FR - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    dz_state_e          state_reg;
    logic [ROW_W-1:0]   row_idx_reg;
    logic [SLOT_W-1:0]  slot_cnt_reg;
    logic [BLANK_W-1:0] blank_cnt_reg;
    logic [FR_W-1:0]    frame_cnt_reg;
    logic               blink_on_reg;
    logic [NUM_W-1:0]   num_q_reg;
    logic [1:0]         mode_q_reg;
`ifdef DZ_BRIGHTNESS_EN
    logic [2:0]         bright_q_reg;
    logic [2:0]         bright_next;
`endif

    // ------------------------------------------------------------------
    // Look-ahead: values that will hold after the coming edge. Outputs are
    // registered, so the pattern for the row about to be driven is looked
    // up one cycle early; row select and columns then switch together.
    // ------------------------------------------------------------------
    logic               scan_done;
    logic               blank_done;
    logic               advance;
    logic               wrap;
    logic               start;
    logic               relatch;
    logic               blink_toggle;
    logic [ROW_W-1:0]   row_idx_next;
    logic [SLOT_W-1:0]  slot_next;
    logic [NUM_W-1:0]   num_next;
    logic [1:0]         mode_next;
    logic               blink_next;
    logic [FR_W-1:0]    frame_next;
    logic [ROWS-1:0]    row_drive;
    logic [COLS-1:0]    pat;
    logic [COLS-1:0]    colg_next;
    logic [COLS-1:0]    colr_next;

    always_comb begin
        scan_done    = (state_reg == SCAN)  && (slot_cnt_reg == SLOT_LAST);
        blank_done   = (state_reg == BLANK) && (blank_cnt_reg == BLANK_LAST);
        // Without blanking the end of a SCAN slot moves straight to the next row.
        advance      = blank_done || (scan_done && (BLANK_CYC == 0));
        wrap         = advance && (row_idx_reg == ROW_LAST);
        start        = (state_reg == IDLE) && en;
        relatch      = start || wrap;
        blink_toggle = wrap && (frame_cnt_reg == FR_LAST);

        row_idx_next = row_idx_reg;
        if (relatch) begin
            row_idx_next = '0;
        end else if (advance) begin
            row_idx_next = row_idx_reg + 1'b1;
        end

        slot_next = (relatch || advance) ? '0 : slot_cnt_reg + 1'b1;
        num_next  = relatch ? num  : num_q_reg;
        mode_next = relatch ? mode : mode_q_reg;
`ifdef DZ_BRIGHTNESS_EN
        bright_next = relatch ? bright : bright_q_reg;
`endif
        blink_next = blink_toggle ? ~blink_on_reg : blink_on_reg;

        frame_next = frame_cnt_reg;
        if (wrap) begin
            frame_next = blink_toggle ? '0 : frame_cnt_reg + 1'b1;
        end

        row_drive = ~(ROWS'(1) << row_idx_next);
    end

    dz_pattern_rom #(
        .NUM_W (NUM_W),
        .ROW_W (ROW_W),
        .COLS  (COLS)
    ) u_rom (
        .num_q   (num_next),
        .row_idx (row_idx_next),
        .pat     (pat)
    );

    // Colour gating (and brightness sub-slot gating) of the looked-up row.
    always_comb begin
        colg_next = '0;
        colr_next = '0;
        case (mode_next)
            MODE_GREEN: colg_next = pat;
            MODE_RED:   colr_next = pat;
            MODE_AMBER: begin
                colg_next = pat;
                colr_next = pat;
            end
            MODE_BLINK: colg_next = blink_next ? pat : '0;
            default: begin
                colg_next = '0;
                colr_next = '0;
            end
        endcase
`ifdef DZ_BRIGHTNESS_EN
        // Lit for the first bright+1 sub-slots, dark for the rest of the slot.
        if (int'(slot_next) >= (int'(bright_next) + 1) * ROW_CYC) begin
            colg_next = '0;
            colr_next = '0;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Scan FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            row_idx_reg   <= '0;
            slot_cnt_reg  <= '0;
            blank_cnt_reg <= '0;
            frame_cnt_reg <= '0;
            blink_on_reg  <= 1'b1;
            num_q_reg     <= '0;
            mode_q_reg    <= '0;
`ifdef DZ_BRIGHTNESS_EN
            bright_q_reg  <= '0;
`endif
            row           <= '1;
            colg          <= '0;
            colr          <= '0;
            frame_start   <= 1'b0;
        end else if (!en) begin
            // Disabled: blank and restart from row 0 with blink phase on.
            state_reg     <= IDLE;
            row_idx_reg   <= '0;
            slot_cnt_reg  <= '0;
            blank_cnt_reg <= '0;
            frame_cnt_reg <= '0;
            blink_on_reg  <= 1'b1;
            row           <= '1;
            colg          <= '0;
            colr          <= '0;
            frame_start   <= 1'b0;
        end else begin
            // Look-ahead values already encode "hold unless relatch/advance".
            row_idx_reg   <= row_idx_next;
            num_q_reg     <= num_next;
            mode_q_reg    <= mode_next;
`ifdef DZ_BRIGHTNESS_EN
            bright_q_reg  <= bright_next;
`endif
            blink_on_reg  <= blink_next;
            frame_cnt_reg <= frame_next;

            case (state_reg)
                IDLE: begin
                    state_reg    <= SCAN;
                    slot_cnt_reg <= '0;
                    row          <= row_drive;
                    colg         <= colg_next;
                    colr         <= colr_next;
                    frame_start  <= 1'b1;
                end
                SCAN: begin
                    if (scan_done && (BLANK_CYC > 0)) begin
                        state_reg     <= BLANK;
                        blank_cnt_reg <= '0;
                        row           <= '1;
                        colg          <= '0;
                        colr          <= '0;
                        frame_start   <= 1'b0;
                    end else begin
                        // Either the same row continues or (no blanking) the
                        // next row starts; slot_next already covers both.
                        state_reg    <= SCAN;
                        slot_cnt_reg <= slot_next;
                        row          <= row_drive;
                        colg         <= colg_next;
                        colr         <= colr_next;
                        frame_start  <= wrap;
                    end
                end
                BLANK: begin
                    if (blank_done) begin
                        state_reg    <= SCAN;
                        slot_cnt_reg <= '0;
                        row          <= row_drive;
                        colg         <= colg_next;
                        colr         <= colr_next;
                        frame_start  <= wrap;
                    end else begin
                        blank_cnt_reg <= blank_cnt_reg + 1'b1;
                        row           <= '1;
                        colg          <= '0;
                        colr          <= '0;
                        frame_start   <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    row         <= '1;
                    colg        <= '0;
                    colr        <= '0;
                    frame_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dz_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dz_scan_ctrl
// Directed bench for dz_scan_ctrl with ROWS=COLS=8, ROW_CYC=1, BLANK_CYC=1,
// BLINK_FR=2. Expected glyph rows are written out by hand.
// With DZ_BRIGHTNESS_EN defined the brightness slot timing is exercised.
// -----------------------------------------------------------------------------
module tb_dz_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] num;
    logic [1:0] mode;
`ifdef DZ_BRIGHTNESS_EN
    logic [2:0] bright;
`endif
    logic [7:0] row;
    logic [7:0] colg;
    logic [7:0] colr;
    logic       frame_start;

    int total = 0;
    int bad   = 0;

    // Hand-written glyphs, row r in bits [r*8 +: 8].
    localparam logic [63:0] G0   = 64'h00_00_18_3C_3C_18_00_00;
    localparam logic [63:0] G1   = 64'h00_18_3C_3C_3C_3C_18_00;
    localparam logic [63:0] G5   = 64'hFF_FF_FF_FF_FF_FF_FF_FF;
    localparam logic [63:0] GOFF = 64'h0;

    dz_scan_ctrl #(
        .ROWS      (8),
        .COLS      (8),
        .NUM_W     (4),
        .ROW_CYC   (1),
        .BLANK_CYC (1),
        .BLINK_FR  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .num         (num),
        .mode        (mode),
`ifdef DZ_BRIGHTNESS_EN
        .bright      (bright),
`endif
        .row         (row),
        .colg        (colg),
        .colr        (colr),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic [7:0] er, input logic [7:0] eg,
                            input logic [7:0] ecr, input logic efs);
        chk({tag, "_row"}, 32'(row), 32'(er));
        chk({tag, "_colg"}, 32'(colg), 32'(eg));
        chk({tag, "_colr"}, 32'(colr), 32'(ecr));
        chk({tag, "_fs"}, 32'(frame_start), 32'(efs));
    endtask

    // One full 16-cycle frame starting with the edge that drives row 0.
    // At cycle chg_k (if >= 0) num is changed to chg_num after checking.
    task automatic run_frame(input string name, input logic [63:0] pat, input logic g_on,
                             input logic r_on, input int chg_k, input logic [3:0] chg_num);
        logic [7:0] er, eg, ecr, p;
        int r;
        for (int k = 0; k < 16; k++) begin
            tick();
            r = k / 2;
            if ((k % 2) == 0) begin
                p   = pat[r*8 +: 8];
                er  = ~(8'h01 << r);
                eg  = g_on ? p : 8'h00;
                ecr = r_on ? p : 8'h00;
            end else begin
                er  = 8'hFF;
                eg  = 8'h00;
                ecr = 8'h00;
            end
            chk_outs($sformatf("%s_c%0d", name, k), er, eg, ecr, (k == 0));
            if (k == chg_k) num = chg_num;
        end
        $display("frame %s checked: total=%0d", name, total);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        num   = 4'd0;
        mode  = 2'b00;
`ifdef DZ_BRIGHTNESS_EN
        bright = 3'd0;
`endif
        tick();
        tick();
        chk_outs("reset", 8'hFF, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b1;

`ifdef DZ_BRIGHTNESS_EN
        // bright=3: columns lit for 4 of 8 cycles, row low all 8, then blank.
        num    = 4'd5;
        mode   = 2'b00;
        bright = 3'd3;
        en     = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k < 8) begin
                chk_outs($sformatf("br_c%0d", k), 8'hFE, (k < 4) ? 8'hFF : 8'h00, 8'h00, (k == 0));
            end else if (k == 8) begin
                chk_outs("br_blank", 8'hFF, 8'h00, 8'h00, 1'b0);
            end else begin
                chk_outs("br_row1", 8'hFD, 8'hFF, 8'h00, 1'b0);
            end
        end
        $display("brightness slot checked: total=%0d", total);
`else
        // Green full egg, two consecutive frames (frame_start every 16 cycles).
        num  = 4'd5;
        mode = 2'b00;
        en   = 1'b1;
        run_frame("green5_a", G5, 1'b1, 1'b0, -1, 4'd0);
        run_frame("green5_b", G5, 1'b1, 1'b0, -1, 4'd0);

        // Red glyph 0, num changes mid-frame: new glyph only after the wrap.
        en = 1'b0;
        tick();
        chk_outs("idle1", 8'hFF, 8'h00, 8'h00, 1'b0);
        num  = 4'd0;
        mode = 2'b01;
        en   = 1'b1;
        run_frame("red0", G0, 1'b0, 1'b1, 5, 4'd1);
        run_frame("red1", G1, 1'b0, 1'b1, -1, 4'd0);

        // Green blink, two frames on, two off, then on again.
        en = 1'b0;
        tick();
        num  = 4'd0;
        mode = 2'b11;
        en   = 1'b1;
        run_frame("blk_on_a", G0, 1'b1, 1'b0, -1, 4'd0);
        run_frame("blk_on_b", G0, 1'b1, 1'b0, -1, 4'd0);
        run_frame("blk_off_a", G0, 1'b0, 1'b0, -1, 4'd0);
        run_frame("blk_off_b", G0, 1'b0, 1'b0, -1, 4'd0);
        run_frame("blk_on_c", G0, 1'b1, 1'b0, -1, 4'd0);

        // Amber, en dropped while row 4 is driven, then re-enabled.
        en = 1'b0;
        tick();
        num  = 4'd5;
        mode = 2'b10;
        en   = 1'b1;
        for (int k = 0; k < 9; k++) tick();
        chk_outs("amber_row4", 8'hEF, 8'hFF, 8'hFF, 1'b0);
        en = 1'b0;
        tick();
        chk_outs("en_drop", 8'hFF, 8'h00, 8'h00, 1'b0);
        tick();
        chk_outs("en_low_hold", 8'hFF, 8'h00, 8'h00, 1'b0);
        en = 1'b1;
        tick();
        chk_outs("en_again", 8'hFE, 8'hFF, 8'hFF, 1'b1);
        $display("en drop/re-enable checked: total=%0d", total);

        // Undefined glyph: rows still scan, columns stay dark.
        en = 1'b0;
        tick();
        num = 4'd15;
        en  = 1'b1;
        run_frame("undef15", GOFF, 1'b1, 1'b1, -1, 4'd0);

        // Asynchronous reset in the middle of row 1.
        tick();
        tick();
        tick();
        chk_outs("pre_rst_row1", 8'hFD, 8'h00, 8'h00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("async_rst", 8'hFF, 8'h00, 8'h00, 1'b0);
        tick();
        chk_outs("rst_hold", 8'hFF, 8'h00, 8'h00, 1'b0);
        num  = 4'd5;
        mode = 2'b00;
        rst_n = 1'b1;
        tick();
        chk_outs("post_rst", 8'hFE, 8'hFF, 8'h00, 1'b1);
        $display("async reset checked: total=%0d", total);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
